// File: rtl/genius_datapath_if.sv
// -----------------------------------------------------------------------------
// genius_datapath_if
// Bundles the controller <-> datapath signals of the Genius memory game.
//   master : the game controller (drives strobes, seed and keys, reads status)
//   slave  : the datapath (reads strobes, drives LED, score and status flags)
// Signals:
//   R1, R2, E1..E4, SEL  controller strobes
//   SW[7:0]              LFSR seed
//   KEY[3:0]             user buttons (synchronised, debounced, active-high)
//   LED[3:0]             colour / result display
//   score[4:0]           rounds completed
//   end_FPGA, end_User, end_time, match, win   status flags
// -----------------------------------------------------------------------------
interface genius_datapath_if;
    logic       R1;
    logic       R2;
    logic       E1;
    logic       E2;
    logic       E3;
    logic       E4;
    logic       SEL;
    logic [7:0] SW;
    logic [3:0] KEY;
    logic [3:0] LED;
    logic [4:0] score;
    logic       end_FPGA;
    logic       end_User;
    logic       end_time;
    logic       match;
    logic       win;

    modport master (
        output R1, R2, E1, E2, E3, E4, SEL, SW, KEY,
        input  LED, score, end_FPGA, end_User, end_time, match, win
    );

    modport slave (
        input  R1, R2, E1, E2, E3, E4, SEL, SW, KEY,
        output LED, score, end_FPGA, end_User, end_time, match, win
    );
endinterface

// File: rtl/genius_datapath.sv
// -----------------------------------------------------------------------------
// genius_datapath
// Datapath responder to the Genius game controller: scrambles a colour
// sequence with an LFSR, plays it back on the LEDs, captures user key presses
// with an idle timeout, compares them, counts rounds/score and shows the result.
// Ports:
//   CLOCK  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    genius_datapath_if.slave (strobes in, LED/score/flags out)
// Optional feature: define GENIUS_SPEEDUP_EN to halve the lit step length
// every 4 rounds (minimum 1 cycle); the dark gap is unchanged.
// -----------------------------------------------------------------------------
module genius_datapath #(
    parameter int N_ROUNDS    = 16,
    parameter int STEP_CYC    = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 10
) (
    input  logic             CLOCK,
    input  logic             reset,
    genius_datapath_if.slave bus
);
    localparam int RND_W = $clog2(N_ROUNDS) + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam int PH_W  = $clog2(STEP_CYC + GAP_CYC) + 1;
    localparam int SEQ_W = 2 * N_ROUNDS;

    logic [7:0]       lfsr_q;
    logic [SEQ_W-1:0] seq_q;
    logic [RND_W-1:0] rnd_q;
    logic [RND_W-1:0] score_q;
    logic [RND_W-1:0] idx_q;
    logic [RND_W-1:0] uidx_q;
    logic [PH_W-1:0]  phase_q;
    logic [TMR_W-1:0] timer_q;
    logic [3:0]       key_prev_q;
    logic [3:0]       led_q;
    logic             r2_prev_q;
    logic             err_q;
    logic             end_fpga_q;
    logic             end_user_q;
    logic             end_time_q;
    logic             match_q;

    logic             act_e3;
    logic             act_e2;
    logic             press;
    logic             user_press;
    logic             win;
    logic [1:0]       play_colour;
    logic [1:0]       user_colour;
    logic [3:0]       play_led;
    logic [PH_W-1:0]  step_len;
    logic [PH_W-1:0]  phase_last;
    logic             unused_e4;

    // E4 only qualifies when the controller looks at match; nothing here uses it.
    assign unused_e4 = bus.E4;

    // Strobe priority R1 > R2 > E1 > E3 > E2; only the two phases with
    // LED side effects need an explicit "active" decode.
    assign act_e3 = !bus.R1 && !bus.R2 && !bus.E1 && bus.E3;
    assign act_e2 = !bus.R1 && !bus.R2 && !bus.E1 && !bus.E3 && bus.E2;

    // A press is a 0000 -> non-zero transition, so keys held before E2 never count.
    assign press      = (key_prev_q == 4'b0000) && (bus.KEY != 4'b0000);
    assign user_press = act_e2 && press && (uidx_q != rnd_q);

    assign play_colour = seq_q[2*int'(idx_q) +: 2];
    assign user_colour = seq_q[2*int'(uidx_q) +: 2];

`ifdef GENIUS_SPEEDUP_EN
    int step_raw;
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        step_raw = STEP_CYC >> ((int'(rnd_q) - 1) / 4);
        step_len = (step_raw < 1) ? PH_W'(1) : PH_W'(step_raw);
    end
`else
    assign step_len = PH_W'(STEP_CYC);
`endif

    assign phase_last = step_len + PH_W'(GAP_CYC - 1);
    assign play_led   = ((idx_q != rnd_q) && (phase_q < step_len)) ? (4'b0001 << play_colour)
                                                                   : 4'b0000;

    assign win = (score_q == RND_W'(N_ROUNDS));

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            lfsr_q     <= 8'h01;
            seq_q      <= '0;
            rnd_q      <= RND_W'(1);
            score_q    <= '0;
            idx_q      <= '0;
            uidx_q     <= '0;
            phase_q    <= '0;
            timer_q    <= '0;
            key_prev_q <= '0;
            r2_prev_q  <= 1'b0;
            err_q      <= 1'b0;
            end_fpga_q <= 1'b0;
            end_user_q <= 1'b0;
            end_time_q <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            // NOTE: state is updated with <= so every branch sees last cycle's values.
            key_prev_q <= bus.KEY;
            r2_prev_q  <= bus.R2;

            if (!bus.E3) begin
                idx_q      <= '0;
                phase_q    <= '0;
                end_fpga_q <= 1'b0;
            end

            if (bus.R1) begin
                lfsr_q     <= (bus.SW == 8'h00) ? 8'hA5 : bus.SW;
                rnd_q      <= RND_W'(1);
                score_q    <= '0;
                seq_q      <= '0;
                err_q      <= 1'b0;
                uidx_q     <= '0;
                timer_q    <= '0;
                end_fpga_q <= 1'b0;
                end_user_q <= 1'b0;
                end_time_q <= 1'b0;
                match_q    <= 1'b0;
            end else if (bus.R2) begin
                if (!r2_prev_q) begin
                    if (match_q) begin
                        score_q <= rnd_q;
                        if (rnd_q != RND_W'(N_ROUNDS)) rnd_q <= rnd_q + 1'b1;
                    end
                    uidx_q     <= '0;
                    timer_q    <= '0;
                    err_q      <= 1'b0;
                    end_user_q <= 1'b0;
                    end_time_q <= 1'b0;
                    match_q    <= 1'b0;
                end
            end else if (bus.E1) begin
                // Galois LFSR, x^8+x^6+x^5+x^4+1 (right-shifting, tap mask B8).
                lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
                seq_q  <= {seq_q[SEQ_W-3:0], lfsr_q[1:0]};
            end else if (bus.E3) begin
                if (idx_q == rnd_q) begin
                    end_fpga_q <= 1'b1;
                end else if (phase_q == phase_last) begin
                    phase_q <= '0;
                    idx_q   <= idx_q + 1'b1;
                end else begin
                    phase_q <= phase_q + 1'b1;
                end
            end else if (bus.E2) begin
                if (uidx_q == rnd_q) begin
                    // Whole round entered; further presses are ignored.
                    end_user_q <= 1'b1;
                    match_q    <= !err_q;
                end else if (press) begin
                    err_q   <= err_q | (bus.KEY != (4'b0001 << user_colour));
                    uidx_q  <= uidx_q + 1'b1;
                    timer_q <= '0;
                end else begin
                    if (timer_q != TMR_W'(TIMEOUT_CYC)) timer_q <= timer_q + 1'b1;
                    if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) end_time_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            led_q <= '0;
        end else if (bus.R1) begin
            led_q <= '0;
        end else if (bus.SEL) begin
            led_q <= win ? 4'b1111 : 4'b1001;
        end else if (act_e3) begin
            led_q <= play_led;
        end else if (act_e2) begin
            if (user_press) led_q <= bus.KEY;
        end else begin
            led_q <= '0;
        end
    end

    assign bus.LED      = led_q;
    assign bus.score    = 5'(score_q);
    assign bus.end_FPGA = end_fpga_q;
    assign bus.end_User = end_user_q;
    assign bus.end_time = end_time_q;
    assign bus.match    = match_q;
    assign bus.win      = win;
endmodule

// File: tb/tb_genius_datapath.sv
// -----------------------------------------------------------------------------
// tb_genius_datapath
// Directed bench for genius_datapath built with N_ROUNDS=2 so a full game,
// score saturation and the win display fit in a short run. A reference LFSR
// and sequence model predict the playback colours and the correct keys.
// -----------------------------------------------------------------------------
module tb_genius_datapath;
    localparam int NR   = 2;
    localparam int STEP = 4;
    localparam int GAP  = 2;
    localparam int TOUT = 10;

    typedef struct {
        logic [3:0] led;
        logic       fpga;
    } exp_t;

    logic CLOCK;
    logic reset;

    genius_datapath_if bus();

    genius_datapath #(
        .N_ROUNDS(NR), .STEP_CYC(STEP), .GAP_CYC(GAP), .TIMEOUT_CYC(TOUT)
    ) dut (
        .CLOCK(CLOCK),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    exp_t              sb[$];
    logic [7:0]        m_lfsr;
    logic [2*NR-1:0]   m_seq;
    int                m_rnd;
    int                m_score;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [3:0] exp_led(input int i);
        logic [1:0] c;
        c = m_seq[2*i +: 2];
        return 4'b0001 << c;
    endfunction

    task automatic scramble(input int n);
        bus.E1 = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            m_seq  = {m_seq[2*NR-3:0], m_lfsr[1:0]};
            m_lfsr = lfsr_next(m_lfsr);
        end
        bus.E1 = 1'b0;
    endtask

    // Expected LED/end_FPGA per enabled E3 cycle, followed by 'hold' done cycles.
    task automatic push_playback(input int hold);
        exp_t e;
        for (int i = 0; i < m_rnd; i++) begin
            for (int c = 0; c < STEP; c++) begin e.led = exp_led(i); e.fpga = 1'b0; sb.push_back(e); end
            for (int c = 0; c < GAP; c++)  begin e.led = 4'b0000;    e.fpga = 1'b0; sb.push_back(e); end
        end
        for (int c = 0; c < hold; c++) begin e.led = 4'b0000; e.fpga = 1'b1; sb.push_back(e); end
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            check({tag, "_led"},  bus.LED,      e.led);
            check({tag, "_fpga"}, bus.end_FPGA, e.fpga);
        end
    endtask

    task automatic press_key(input logic [3:0] k);
        bus.KEY = k;
        tick();
        bus.KEY = 4'b0000;
        tick();
    endtask

    initial begin
        reset   = 1'b0;
        bus.R1  = 1'b0; bus.R2 = 1'b0; bus.E1 = 1'b0; bus.E2 = 1'b0;
        bus.E3  = 1'b0; bus.E4 = 1'b0; bus.SEL = 1'b0;
        bus.SW  = 8'h00; bus.KEY = 4'b0000;
        m_lfsr  = 8'h01; m_seq = '0; m_rnd = 1; m_score = 0;

        // Reset state
        #12;
        check("rst_led", bus.LED, 0);
        check("rst_score", bus.score, 0);
        check("rst_fpga", bus.end_FPGA, 0);
        check("rst_user", bus.end_User, 0);
        check("rst_time", bus.end_time, 0);
        check("rst_match", bus.match, 0);
        check("rst_win", bus.win, 0);
        reset = 1'b1;
        tick();

        // Init with zero seed -> A5
        bus.R1 = 1'b1; tick(); bus.R1 = 1'b0;
        m_lfsr = 8'hA5; m_seq = '0; m_rnd = 1; m_score = 0;
        check("init_score", bus.score, 0);
        check("init_led", bus.LED, 0);
        check("init_win", bus.win, 0);

        // Scramble, then round-1 playback
        scramble(20);
        bus.E3 = 1'b1;
        push_playback(2);
        drain("pb1");
        bus.E3 = 1'b0; tick();
        check("pb1_exit_fpga", bus.end_FPGA, 0);

        // Round 1: correct key
        bus.E2 = 1'b1;
        tick(); tick();
        bus.KEY = exp_led(0); tick();
        check("r1_echo", bus.LED, exp_led(0));
        check("r1_user_early", bus.end_User, 0);
        bus.KEY = 4'b0000; tick();
        check("r1_user", bus.end_User, 1);
        check("r1_match", bus.match, 1);
        bus.E4 = 1'b1; tick();
        check("r1_match_e4", bus.match, 1);
        bus.E4 = 1'b0; bus.E2 = 1'b0;
        bus.R2 = 1'b1; tick(); tick(); bus.R2 = 1'b0;
        m_score = m_rnd; m_rnd = (m_rnd < NR) ? m_rnd + 1 : NR;
        check("r1_score", bus.score, m_score);
        check("r1_user_clr", bus.end_User, 0);
        check("r1_match_clr", bus.match, 0);
        bus.SEL = 1'b1; tick(); bus.SEL = 1'b0;
        check("sel_lose", bus.LED, 4'b1001);
        tick();

        // Round 2: first key right, second a multi-key press
        bus.E3 = 1'b1;
        push_playback(1);
        drain("pb2");
        bus.E3 = 1'b0; tick();
        bus.E2 = 1'b1;
        press_key(exp_led(0));
        check("r2a_user_early", bus.end_User, 0);
        bus.KEY = 4'b0011; tick();
        check("r2a_echo", bus.LED, 4'b0011);
        bus.KEY = 4'b0000; tick();
        check("r2a_user", bus.end_User, 1);
        check("r2a_match", bus.match, 0);
        bus.KEY = 4'b0100; tick(); bus.KEY = 4'b0000;
        check("r2a_ignored", bus.LED, 4'b0011);
        bus.E2 = 1'b0;
        bus.R2 = 1'b1; tick(); bus.R2 = 1'b0;
        check("r2a_score", bus.score, m_score);
        tick();

        // Timeout with no press
        bus.E2 = 1'b1;
        for (int i = 1; i < TOUT; i++) begin
            tick();
            check("tout_early", bus.end_time, 0);
        end
        tick();
        check("tout_set", bus.end_time, 1);
        tick(); tick();
        check("tout_sticky", bus.end_time, 1);
        bus.E2 = 1'b0;
        bus.R2 = 1'b1; tick(); bus.R2 = 1'b0;
        check("tout_clr", bus.end_time, 0);
        tick();

        // Press on the timeout cycle wins, then finish round 2 correctly
        bus.E2 = 1'b1;
        for (int i = 1; i < TOUT; i++) tick();
        bus.KEY = exp_led(0); tick();
        check("tout_press_time", bus.end_time, 0);
        check("tout_press_echo", bus.LED, exp_led(0));
        bus.KEY = 4'b0000; tick();
        press_key(exp_led(1));
        check("r2b_user", bus.end_User, 1);
        check("r2b_match", bus.match, 1);
        bus.E2 = 1'b0;
        bus.R2 = 1'b1; tick(); bus.R2 = 1'b0;
        m_score = m_rnd; m_rnd = (m_rnd < NR) ? m_rnd + 1 : NR;
        check("r2b_score", bus.score, m_score);
        check("r2b_win", bus.win, 1);
        tick();
        check("win_hold", bus.win, 1);
        bus.SEL = 1'b1; tick(); bus.SEL = 1'b0;
        check("sel_win", bus.LED, 4'b1111);
        check("sel_score", bus.score, m_score);
        tick();

        // rnd saturated at NR: playback still two steps
        bus.E3 = 1'b1;
        push_playback(1);
        drain("pb_sat");
        bus.E3 = 1'b0; tick();

        // Async reset while a colour is lit
        bus.E3 = 1'b1; tick(); tick();
        check("pre_rst_led", bus.LED, exp_led(0));
        #2 reset = 1'b0;
        #1;
        check("mid_rst_led", bus.LED, 0);
        check("mid_rst_score", bus.score, 0);
        check("mid_rst_win", bus.win, 0);
        tick();
        check("mid_rst_hold", bus.LED, 0);
        bus.E3 = 1'b0;
        reset = 1'b1;
        tick();

        // New game with a non-zero seed; held key before E2 is not a press
        bus.SW = 8'h3C; bus.R1 = 1'b1; tick(); bus.R1 = 1'b0;
        m_lfsr = 8'h3C; m_seq = '0; m_rnd = 1; m_score = 0;
        bus.KEY = 4'b0001; tick();
        bus.E2 = 1'b1; tick(); tick();
        check("held_key", bus.LED, 0);
        bus.E2 = 1'b0; bus.KEY = 4'b0000; tick();
        scramble(7);
        bus.E3 = 1'b1;
        push_playback(2);
        drain("pb_seed");
        #2 reset = 1'b0;
        #1;
        check("rst_fpga_async", bus.end_FPGA, 0);
        check("rst_led_async", bus.LED, 0);
        bus.E3 = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
